// File: rtl/sra_pkg.sv
// Shared SRA protocol types.
// Holds the transaction, response, master status and master state encodings.
// basic_sra_master and basic_sra_slave both import this package.
package sra_pkg;

  typedef enum logic {
    TRANS_WRITE = 1'b0,
    TRANS_READ  = 1'b1
  } trans_t;

  typedef enum logic {
    RSP_SUCCESS = 1'b0,
    RSP_FAIL    = 1'b1
  } response_t;

  typedef enum logic [1:0] {
    MSTAT_OK      = 2'd0,
    MSTAT_FAIL    = 2'd1,
    MSTAT_TIMEOUT = 2'd2
  } mstat_t;

  typedef enum logic [1:0] {
    MST_IDLE     = 2'd0,
    MST_REQ      = 2'd1,
    MST_WAIT_RSP = 2'd2,
    MST_DONE     = 2'd3
  } mstate_t;

  // Maps the slave response user bit onto a completion status.
  function automatic mstat_t rsp_to_status(input logic rsp_user);
    return (rsp_user == RSP_SUCCESS) ? MSTAT_OK : MSTAT_FAIL;
  endfunction

endpackage

// File: rtl/sra_timeout_counter.sv
// Response timeout counter for the SRA master.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear_i     - synchronous clear to zero (wins over enable_i)
//   enable_i    - count one step this cycle
//   expired_o   - high while the count equals TIMEOUT_CYCLES-1
module sra_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // The count holds at LAST so it can never wrap back below the boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/basic_sra_master.sv
// SRA master-side initiator: one local command at a time, driven onto the
// SRA request channel, completed by the slave response or by a timeout.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid source holds its payload stable until that edge and
// never withdraws valid before it.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   cmd_*               - local command channel (user: 0 write, 1 read)
//   req_*               - SRA request channel towards the slave
//   rsp_*               - SRA response channel from the slave (user: 0 ok, 1 fail)
//   done_valid          - one-cycle completion pulse
//   done_status/rdata   - completion status (0 ok, 1 fail, 2 timeout) and read data
//   stray_rsp           - sticky flag: response seen while none was expected
//   dbg_state_o         - current FSM state
module basic_sra_master
  import sra_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_user,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_user,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic              rsp_user,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              done_valid,
  output logic [1:0]        done_status,
  output logic [DATA_W-1:0] done_rdata,
  output logic              stray_rsp,
  output mstate_t           dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mstate_t           state_q;
  logic              req_valid_q;
  logic              req_user_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_data_q;
  logic              done_valid_q;
  mstat_t            done_status_q;
  logic [DATA_W-1:0] done_rdata_q;
  logic              stray_q;
  logic              req_hs;
  logic              expired;

  assign req_hs = (state_q == MST_REQ) && req_ready;

  sra_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (req_hs),
    .enable_i  (state_q == MST_WAIT_RSP),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= MST_IDLE;
      req_valid_q   <= 1'b0;
      req_user_q    <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      done_valid_q  <= 1'b0;
      done_status_q <= MSTAT_OK;
      done_rdata_q  <= '0;
      stray_q       <= 1'b0;
    end else begin
      done_valid_q <= 1'b0;
      // Responses are always accepted; outside WAIT_RSP they are dropped.
      if (rsp_valid && (state_q != MST_WAIT_RSP)) begin
        stray_q <= 1'b1;
      end
      case (state_q)
        MST_IDLE: begin
          if (cmd_valid) begin
            req_user_q  <= cmd_user;
            req_addr_q  <= cmd_addr;
            req_data_q  <= cmd_wdata;
            req_valid_q <= 1'b1;
            state_q     <= MST_REQ;
          end
        end
        MST_REQ: begin
          if (req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= MST_WAIT_RSP;
          end
        end
        MST_WAIT_RSP: begin
          // A response in the expiry cycle still counts as a real response.
          if (rsp_valid) begin
            done_status_q <= rsp_to_status(rsp_user);
            done_rdata_q  <= ((req_user_q == TRANS_READ) && (rsp_user == RSP_SUCCESS))
                             ? rsp_data : '0;
            done_valid_q  <= 1'b1;
            state_q       <= MST_DONE;
          end else if (expired) begin
            done_status_q <= MSTAT_TIMEOUT;
            done_rdata_q  <= '0;
            done_valid_q  <= 1'b1;
            state_q       <= MST_DONE;
          end
        end
        MST_DONE: begin
          state_q <= MST_IDLE;
        end
        default: begin
          state_q <= MST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == MST_IDLE);
  // Every state accepts responses so a late slave can never stall.
  assign rsp_ready   = 1'b1;
  assign req_valid   = req_valid_q;
  assign req_user    = req_user_q;
  assign req_addr    = req_addr_q;
  assign req_data    = req_data_q;
  assign done_valid  = done_valid_q;
  assign done_status = done_status_q;
  assign done_rdata  = done_rdata_q;
  assign stray_rsp   = stray_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_basic_sra_master.sv
module tb_basic_sra_master;
  import sra_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int TO     = 8;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_user;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              req_valid;
  logic              req_ready;
  logic              req_user;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_user;
  logic [DATA_W-1:0] rsp_data;
  logic              done_valid;
  logic [1:0]        done_status;
  logic [DATA_W-1:0] done_rdata;
  logic              stray_rsp;
  mstate_t           dbg_state;

  logic [DATA_W+1:0] exp_q[$];
  int n_checks   = 0;
  int n_pass     = 0;
  int done_count = 0;
  time last_accept_t = 0;
  time prev_accept_t = 0;

  basic_sra_master #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_user    (cmd_user),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_user    (req_user),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_user    (rsp_user),
    .rsp_data    (rsp_data),
    .done_valid  (done_valid),
    .done_status (done_status),
    .done_rdata  (done_rdata),
    .stray_rsp   (stray_rsp),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every done pulse pops one expected {status, rdata}
  always @(negedge clk) begin
    if (done_valid === 1'b1) begin
      logic [DATA_W+1:0] e;
      done_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL done_unexpected: got status=%0d rdata=%h, required no done pulse",
                 done_status, done_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({done_status, done_rdata} !== e) begin
          $display("FAIL done_scoreboard: got status=%0d rdata=%h, required status=%0d rdata=%h",
                   done_status, done_rdata, e[DATA_W+1:DATA_W], e[DATA_W-1:0]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_idle(input string name);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) $display("FAIL %s_idle_wait: cmd_ready=%b, required 1", name, cmd_ready);
    else n_pass++;
  endtask

  // rsp_delay < 0: the slave never answers.
  task automatic do_txn(input logic user, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int stall,
                        input int rsp_delay, input logic ruser,
                        input logic [DATA_W-1:0] rdata, input string name);
    logic [1:0]        es;
    logic [DATA_W-1:0] er;
    int                cyc;
    int                exp_cyc;
    wait_idle(name);
    es = (rsp_delay < 0) ? 2'd2 : (ruser ? 2'd1 : 2'd0);
    er = (user && !ruser && rsp_delay >= 0) ? rdata : '0;
    exp_cyc = (rsp_delay < 0) ? TO : rsp_delay + 1;
    exp_q.push_back({es, er});
    cmd_valid = 1'b1;
    cmd_user  = user;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    req_ready = 1'b0;
    prev_accept_t = last_accept_t;
    last_accept_t = $time;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_user  = ~user;
    cmd_addr  = ADDR_W'($urandom);
    cmd_wdata = $urandom;
    for (int k = 0; k <= stall; k++) begin
      n_checks++;
      if ({cmd_ready, req_valid, req_user, req_addr, req_data} !== {1'b0, 1'b1, user, addr, wdata})
        $display("FAIL %s_req_cyc%0d: got rdy=%b vld=%b user=%b addr=%h data=%h, required rdy=0 vld=1 user=%b addr=%h data=%h",
                 name, k, cmd_ready, req_valid, req_user, req_addr, req_data, user, addr, wdata);
      else n_pass++;
      req_ready = (k == stall);
      @(negedge clk);
    end
    req_ready = 1'b0;
    n_checks++;
    if (req_valid !== 1'b0) $display("FAIL %s_req_drop: req_valid=%b, required 0", name, req_valid);
    else n_pass++;
    cyc = 0;
    while (cyc < 40) begin
      rsp_valid = (cyc == rsp_delay);
      rsp_user  = ruser;
      rsp_data  = rdata;
      @(negedge clk);
      cyc++;
      if (done_valid === 1'b1) break;
    end
    rsp_valid = 1'b0;
    n_checks++;
    if (cyc !== exp_cyc) $display("FAIL %s_latency: done after %0d cycles, required %0d", name, cyc, exp_cyc);
    else n_pass++;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({req_valid, done_valid, done_status, done_rdata, stray_rsp, cmd_ready, rsp_ready,
         req_user, req_addr, req_data} !== {1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 32'd0})
      $display("FAIL reset_values: vld=%b done=%b st=%0d rd=%h stray=%b crdy=%b rrdy=%b user=%b addr=%h data=%h, required 0 0 0 0 0 1 1 0 0 0",
               req_valid, done_valid, done_status, done_rdata, stray_rsp, cmd_ready, rsp_ready,
               req_user, req_addr, req_data);
    else n_pass++;
    n_checks++;
    if (dbg_state !== MST_IDLE) $display("FAIL reset_state: got %0d, required %0d", dbg_state, MST_IDLE);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    do_txn(1'b0, 16'h0010, 32'hDEADBEEF, 0, 0, 1'b0, 32'hCAFEF00D, "write_zero_wait");
    n_checks++;
    if (stray_rsp !== 1'b0) $display("FAIL write_stray: stray_rsp=%b, required 0", stray_rsp);
    else n_pass++;
  endtask

  task automatic test_read_backpressure();
    do_txn(1'b1, 16'h0044, 32'h0BAD0BAD, 5, 0, 1'b0, 32'h12345678, "read_backpressure");
  endtask

  task automatic test_slave_fail();
    do_txn(1'b1, 16'h0080, 32'h0, 0, 1, 1'b1, 32'hFFFF0000, "slave_fail");
    @(negedge clk);
    n_checks++;
    if ({done_valid, done_status, done_rdata} !== {1'b0, 2'd1, 32'd0})
      $display("FAIL slave_fail_hold: done=%b st=%0d rd=%h, required 0 1 0", done_valid, done_status, done_rdata);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int dc;
    do_txn(1'b1, 16'h00C0, 32'h0, 0, -1, 1'b0, 32'h0, "timeout");
    n_checks++;
    if (stray_rsp !== 1'b0) $display("FAIL timeout_stray_before: stray_rsp=%b, required 0", stray_rsp);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    dc = done_count;
    rsp_valid = 1'b1;
    rsp_user  = 1'b0;
    rsp_data  = 32'h77777777;
    @(negedge clk);
    rsp_valid = 1'b0;
    n_checks++;
    if (stray_rsp !== 1'b1) $display("FAIL timeout_stray_after: stray_rsp=%b, required 1", stray_rsp);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_count !== dc) $display("FAIL timeout_no_second_done: done pulses=%0d, required %0d", done_count, dc);
    else n_pass++;
  endtask

  task automatic test_rsp_at_expiry();
    do_txn(1'b1, 16'h0100, 32'h0, 0, TO - 1, 1'b0, 32'hA5A55A5A, "rsp_at_expiry");
    n_checks++;
    if (stray_rsp !== 1'b1) $display("FAIL stray_sticky: stray_rsp=%b, required 1", stray_rsp);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    // Reset while waiting for the response
    wait_idle("reset_mid");
    cmd_valid = 1'b1; cmd_user = 1'b1; cmd_addr = 16'h0200; cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b0; req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dbg_state !== MST_WAIT_RSP) $display("FAIL reset_mid_pre_state: got %0d, required %0d", dbg_state, MST_WAIT_RSP);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_valid, done_valid, cmd_ready, stray_rsp} !== 4'b0010 || dbg_state !== MST_IDLE)
      $display("FAIL reset_mid_wait: vld=%b done=%b crdy=%b stray=%b state=%0d, required 0 0 1 0 state 0",
               req_valid, done_valid, cmd_ready, stray_rsp, dbg_state);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    // Reset while the request is stalled drops req_valid before any clock edge
    cmd_valid = 1'b1; cmd_user = 1'b0; cmd_addr = 16'h0300; cmd_wdata = 32'h1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_checks++;
    if (req_valid !== 1'b1) $display("FAIL reset_mid_req_pre: req_valid=%b, required 1", req_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_valid, cmd_ready} !== 2'b01) $display("FAIL reset_mid_req_async: vld=%b crdy=%b, required 0 1", req_valid, cmd_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(1'b1, 16'h0404, 32'h0, 1, 2, 1'b0, 32'h0F0F1234, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      do_txn(1'($urandom_range(0, 1)), ADDR_W'($urandom), $urandom, $urandom_range(0, 2),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, "random");
    end
    do_txn(1'b0, 16'h0500, 32'h11112222, 0, 0, 1'b0, 32'h0, "b2b_first");
    do_txn(1'b1, 16'h0504, 32'h0, 0, 0, 1'b0, 32'h33334444, "b2b_second");
    n_checks++;
    if ((last_accept_t - prev_accept_t) !== 40)
      $display("FAIL b2b_throughput: accept interval %0t, required 40", last_accept_t - prev_accept_t);
    else n_pass++;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_user = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_user = 1'b0; rsp_data = '0;
    test_reset();
    test_write_zero_wait();
    test_read_backpressure();
    test_slave_fail();
    test_timeout();
    test_rsp_at_expiry();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d expected completions left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
